// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED PIO with hardware blink: register map and
// address width used by the top-level register file and read mux.
package led_pio_pkg;

  localparam int ADDR_W = 3;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_DATA      = 3'd0;
  localparam addr_t ADDR_OUTSET    = 3'd1;
  localparam addr_t ADDR_OUTCLEAR  = 3'd2;
  localparam addr_t ADDR_BLINK_EN  = 3'd3;
  localparam addr_t ADDR_BLINK_PER = 3'd4;
  localparam addr_t ADDR_STATUS    = 3'd5;

  // A bus write is taken on any edge where the slave is selected and the
  // active-low strobe is asserted.
  function automatic logic bus_write(input logic cs, input logic wr_n);
    return cs & ~wr_n;
  endfunction

endpackage

// File: rtl/led_pio_blink_timer.sv
// Shared blink timer for the LED PIO: a prescaler producing one tick every
// PRESCALE clocks and a half-period counter that toggles phase every
// `period` ticks. Only built when LED_PIO_BLINK_EN is defined.
`ifdef LED_PIO_BLINK_EN
module led_pio_blink_timer #(
  parameter int PRESCALE = 50000,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase
);

  // Prescaler must hold values 0..PRESCALE-1; keep at least one bit so the
  // PRESCALE == 1 case (tick every cycle) still elaborates.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
  localparam logic [PERIOD_W-1:0] PER_ONE  = PERIOD_W'(1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("led_pio_blink_timer: PRESCALE must be >= 1");
  end

  logic [PRE_W-1:0]    pre_cnt;
  logic [PERIOD_W-1:0] per_cnt;
  logic                tick;
  logic                per_last;
  logic                frozen;

  // A zero half-period freezes the blink in its ON phase.
  assign frozen = (period == '0);
  assign tick   = (pre_cnt == PRE_LAST);
  // period - 1 is only consulted when period != 0, so it never wraps; the
  // compare stays within PERIOD_W bits even at the maximum period.
  assign per_last = (per_cnt == (period - PER_ONE));

  // Prescaler, half-period counter and phase; restart or a frozen period
  // pins everything to the start of an ON half-period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      per_cnt <= '0;
      phase   <= 1'b1;
    end else if (restart || frozen) begin
      pre_cnt <= '0;
      per_cnt <= '0;
      phase   <= 1'b1;
    end else begin
      pre_cnt <= tick ? '0 : (pre_cnt + PRE_ONE);
      if (tick) begin
        if (per_last) begin
          per_cnt <= '0;
          phase   <= ~phase;
        end else begin
          per_cnt <= per_cnt + PER_ONE;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/avalon_led_pio_blink.sv
// Avalon-MM output PIO driving board LEDs: DATA register with atomic
// set/clear aliases, zero-latency read mux and a registered out_port.
// Optional per-bit hardware blink (BLINK_EN, BLINK_PER, STATUS and the
// shared timer) is built only when the macro LED_PIO_BLINK_EN is defined;
// otherwise addresses 3-5 read as zero and out_port is a registered DATA.
module avalon_led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0,
  parameter int                PRESCALE    = 50000,
  parameter int                PERIOD_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port
);

  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
    $error("avalon_led_pio_blink: DATA_W must be in 1..32");
  end
  if (PERIOD_W < 1 || PERIOD_W > 32) begin : g_bad_period_w
    $error("avalon_led_pio_blink: PERIOD_W must be in 1..32");
  end

  logic              wr_en;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_next;
  logic [DATA_W-1:0] blink_mask;
  logic              unused_wd;

  assign wr_en = bus_write(chipselect, write_n);
  assign wd    = writedata[DATA_W-1:0];
  // Upper write-data bits are ignored by design.
  assign unused_wd = &{1'b0, writedata};

  // DATA next-state: plain write, atomic OR-set and AND-NOT-clear aliases.
  always_comb begin
    data_next = data_reg;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_next = wd;
        ADDR_OUTSET:   data_next = data_reg | wd;
        ADDR_OUTCLEAR: data_next = data_reg & ~wd;
        default:       data_next = data_reg;
      endcase
    end
  end

  // DATA register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
    end else begin
      data_reg <= data_next;
    end
  end

`ifdef LED_PIO_BLINK_EN
  logic [DATA_W-1:0]   blink_en;
  logic [PERIOD_W-1:0] blink_per;
  logic                per_restart;
  logic                phase;

  // Any write to BLINK_PER restarts the timer at the top of an ON phase;
  // BLINK_EN writes leave the timer running.
  assign per_restart = wr_en && (address == ADDR_BLINK_PER);

  // Blink enable mask and half-period registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_en  <= '0;
      blink_per <= '0;
    end else if (wr_en) begin
      if (address == ADDR_BLINK_EN) begin
        blink_en <= wd;
      end
      if (address == ADDR_BLINK_PER) begin
        blink_per <= writedata[PERIOD_W-1:0];
      end
    end
  end

  led_pio_blink_timer #(
    .PRESCALE (PRESCALE),
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (blink_per),
    .restart (per_restart),
    .phase   (phase)
  );

  // Blinking bits are forced off during the OFF half-period.
  assign blink_mask = blink_en & {DATA_W{~phase}};

  // Zero-latency read mux, zero-extended to the bus width.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(data_reg);
      ADDR_BLINK_EN:  readdata = 32'(blink_en);
      ADDR_BLINK_PER: readdata = 32'(blink_per);
      ADDR_STATUS:    readdata = {31'd0, phase};
      default:        readdata = '0;
    endcase
  end
`else
  assign blink_mask = '0;

  // Zero-latency read mux; only DATA is readable in this build.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(data_reg);
      default:   readdata = '0;
    endcase
  end
`endif

  // LED drive register: one edge behind DATA, with blink masking applied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else begin
      out_port <= data_reg & ~blink_mask;
    end
  end

endmodule

// File: tb/tb_avalon_led_pio_blink.sv
// Self-checking bench for avalon_led_pio_blink. Works for both builds: the
// reference model follows LED_PIO_BLINK_EN to decide whether the blink
// registers exist.
`timescale 1ns/1ps
module tb_avalon_led_pio_blink;

  localparam int          DW = 8;
  localparam logic [7:0]  RV = 8'hA5;
  localparam int          PS = 4;
  localparam int          PW = 4;
`ifdef LED_PIO_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_en;
  logic [DW-1:0] m_out;
  int            m_per;
  int            m_elapsed;   // clock edges since last timer restart

  avalon_led_pio_blink #(
    .DATA_W      (DW),
    .RESET_VALUE (RV),
    .PRESCALE    (PS),
    .PERIOD_W    (PW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #10 clk = ~clk;

  // Phase from elapsed time: one toggle every PS*per clocks, starting ON.
  function automatic logic m_phase();
    if (!BLINK || m_per == 0) return 1'b1;
    return ((m_elapsed / (PS * m_per)) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'd0, m_data};
      3'd3:    return BLINK ? {24'd0, m_en} : 32'd0;
      3'd4:    return BLINK ? m_per : 32'd0;
      3'd5:    return BLINK ? {31'd0, m_phase()} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data    = RV;
    m_en      = '0;
    m_per     = 0;
    m_elapsed = 0;
    m_out     = RV;
  endtask

  task automatic read_chk(input logic [2:0] a, input string name);
    address = a;
    #1;
    check(name, readdata, m_read(a));
  endtask

  // One clock: optional write, model update, then check out_port and readdata.
  task automatic cycle(input bit wr, input logic [2:0] a, input logic [31:0] d);
    logic [DW-1:0] nxt_out;
    bit            restart;
    address    = a;
    chipselect = wr;
    write_n    = ~wr;
    writedata  = d;
    nxt_out = m_data & ~(m_en & {DW{~m_phase()}});
    @(posedge clk);
    restart = 1'b0;
    if (wr) begin
      case (a)
        3'd0: m_data = d[DW-1:0];
        3'd1: m_data = m_data | d[DW-1:0];
        3'd2: m_data = m_data & ~d[DW-1:0];
        3'd3: if (BLINK) m_en = d[DW-1:0];
        3'd4: if (BLINK) begin m_per = int'(d[PW-1:0]); restart = 1'b1; end
        default: ;
      endcase
    end
    m_elapsed = restart ? 0 : m_elapsed + 1;
    m_out = nxt_out;
    #1;
    check("out_port", {24'd0, out_port}, {24'd0, m_out});
    check($sformatf("readdata@%0d", a), readdata, m_read(a));
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    // 1: reset values
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_port", {24'd0, out_port}, 32'h0000_00A5);
    read_chk(3'd0, "rst_data");
    read_chk(3'd3, "rst_blink_en");
    read_chk(3'd4, "rst_blink_per");
    read_chk(3'd5, "rst_status");
    reset_n = 1'b1;

    // 2: DATA / OUTSET / OUTCLEAR
    cycle(1'b1, 3'd0, 32'h0000_000F);
    cycle(1'b1, 3'd1, 32'h0000_0030);
    cycle(1'b1, 3'd2, 32'h0000_0003);
    cycle(1'b0, 3'd0, 32'h0);
    check("t2_data", readdata, 32'h0000_003C);
    check("t2_out_port", {24'd0, out_port}, 32'h0000_003C);

    // 3: blink bit 0 with a 3-tick half-period
    cycle(1'b1, 3'd0, 32'h0000_00FF);
    cycle(1'b1, 3'd3, 32'h0000_0001);
    cycle(1'b1, 3'd4, 32'h0000_0003);
    for (int i = 0; i < 40; i++) cycle(1'b0, 3'd5, 32'h0);

    // 4: restart mid-OFF phase (upper bits of the written period are ignored)
    for (int i = 0; i < 30 && m_phase() != 1'b0; i++) cycle(1'b0, 3'd5, 32'h0);
    cycle(1'b0, 3'd5, 32'h0);
    cycle(1'b1, 3'd4, 32'hFFFF_FFF3);
    for (int i = 0; i < 30; i++) cycle(1'b0, 3'd5, 32'h0);

    // Boundary: half-period 1, then maximum half-period
    cycle(1'b1, 3'd4, 32'h0000_0001);
    for (int i = 0; i < 20; i++) cycle(1'b0, 3'd5, 32'h0);
    cycle(1'b1, 3'd4, 32'h0000_000F);
    for (int i = 0; i < 130; i++) cycle(1'b0, 3'd5, 32'h0);
    cycle(1'b1, 3'd3, 32'h0000_00F0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 3'd0, 32'h0);

    // 5: asynchronous reset mid-blink
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_out_port", {24'd0, out_port}, 32'h0000_00A5);
    read_chk(3'd0, "arst_data");
    read_chk(3'd3, "arst_blink_en");
    read_chk(3'd4, "arst_blink_per");
    read_chk(3'd5, "arst_status");
    @(posedge clk);
    #1;
    check("arst_hold_out_port", {24'd0, out_port}, 32'h0000_00A5);
    reset_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      int          r;
      logic [2:0]  a;
      logic [31:0] d;
      r = int'($urandom_range(0, 99));
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd4) begin
        d[PW-1:0] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      end
      if (r < 25) cycle(1'b1, a, d);
      else        cycle(1'b0, a, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
